// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// holds the PS/2 clock low to inhibit the device, issues the request-to-send
// (start bit), then shifts the data, odd parity and stop bits out on the
// device-generated clock. Finally it checks the device ACK and waits for the
// bus to go idle before reporting the result.
//
// The pins are open-drain. The top level pulls a pin low while its Oe output
// is 1 and tristates it otherwise. The same pins are shared with the scan-code
// receiver.
//
// Parameters
//   INHIBIT_CYCLES  Clock cycles the PS/2 clock is held low before the start bit
//   TIMEOUT_CYCLES  Max Clock cycles allowed between device clock falling edges
//   FILTER_LEN      Consecutive equal synced samples needed to flip the
//                   filtered PS/2 clock
//
// Ports
//   Clock     in   System clock
//   Reset     in   Synchronous, active-high reset
//   TxData    in   [7:0] byte to send, captured when TxStart is accepted
//   TxStart   in   Send request, accepted only while idle
//   TxBusy    out  High from the cycle after acceptance until the result pulse
//   TxDone    out  1-cycle pulse: byte sent and device ACK received
//   TxError   out  1-cycle pulse: device did not ACK, or bus timeout
//   Ps2ClkIn  in   PS/2 clock pin level (asynchronous)
//   Ps2DatIn  in   PS/2 data pin level (asynchronous)
//   Ps2ClkOe  out  1 = pull the PS/2 clock low
//   Ps2DatOe  out  1 = pull the PS/2 data low
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       TxBusy,
  output logic       TxDone,
  output logic       TxError,
  input  logic       Ps2ClkIn,
  input  logic       Ps2DatIn,
  output logic       Ps2ClkOe,
  output logic       Ps2DatOe
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Odd parity: the parity bit makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Input conditioning
  logic           clk_meta_r;
  logic           clk_sync_r;
  logic           dat_meta_r;
  logic           dat_sync_r;
  logic           clk_filt_r;
  logic [FCW-1:0] filt_cnt_r;
  logic           fall_r;

  // FSM state and datapath
  state_t      state_r;
  state_t      state_n;
  logic [10:0] frame_r;
  logic [10:0] frame_n;
  logic [3:0]  bit_idx_r;
  logic [3:0]  bit_idx_n;
  logic [12:0] inh_cnt_r;
  logic [12:0] inh_cnt_n;
  logic [19:0] tmo_cnt_r;
  logic [19:0] tmo_cnt_n;
  logic        ack_err_r;
  logic        ack_err_n;

  // Registered outputs and their next values
  logic clk_oe_r;
  logic dat_oe_r;
  logic busy_r;
  logic done_r;
  logic error_r;
  logic clk_oe_n;
  logic dat_oe_n;
  logic busy_n;
  logic done_n;
  logic error_n;

  logic tmo_active_s;
  logic tmo_hit_s;

  // Two-flop synchronisers for both pins; the idle bus level is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= Ps2ClkIn;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= Ps2DatIn;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Clock glitch filter: the filtered level only follows the synced level after
  // FILTER_LEN consecutive differing samples. fall_r marks the 1->0 flip for one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= {FCW{1'b0}};
      fall_r     <= 1'b0;
    end else if (clk_sync_r == clk_filt_r) begin
      filt_cnt_r <= {FCW{1'b0}};
      fall_r     <= 1'b0;
    end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
      clk_filt_r <= clk_sync_r;
      filt_cnt_r <= {FCW{1'b0}};
      fall_r     <= ~clk_sync_r;
    end else begin
      filt_cnt_r <= filt_cnt_r + FCW'(1);
      fall_r     <= 1'b0;
    end
  end

  // The bus watchdog runs while the device owns the clock and restarts on every device clock fall.
  always_comb begin
    tmo_active_s = (state_r == ST_SEND) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);
    tmo_hit_s    = tmo_active_s && !fall_r && (tmo_cnt_r == 20'(TIMEOUT_CYCLES - 1));
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_n   = state_r;
    frame_n   = frame_r;
    bit_idx_n = bit_idx_r;
    inh_cnt_n = 13'd0;
    ack_err_n = ack_err_r;
    done_n    = 1'b0;
    error_n   = 1'b0;

    if (tmo_active_s && !fall_r) begin
      tmo_cnt_n = tmo_cnt_r + 20'd1;
    end else begin
      tmo_cnt_n = 20'd0;
    end

    case (state_r)
      ST_IDLE: begin
        // The result-pulse cycle is also IDLE, so the earliest new start is the cycle after.
        if (TxStart && !busy_r && !done_r && !error_r) begin
          // LSB is the start bit (0), so the line already shows the start bit when SEND begins.
          frame_n   = {1'b1, odd_parity(TxData), TxData, 1'b0};
          bit_idx_n = 4'd0;
          ack_err_n = 1'b0;
          state_n   = ST_INHIBIT;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_r == 13'(INHIBIT_CYCLES - 1)) begin
          state_n = ST_REQ;
        end else begin
          inh_cnt_n = inh_cnt_r + 13'd1;
        end
      end

      ST_REQ: begin
        state_n = ST_SEND;
      end

      ST_SEND: begin
        if (tmo_hit_s) begin
          error_n = 1'b1;
          state_n = ST_IDLE;
        end else if (fall_r) begin
          // Each device clock fall presents the next bit: idx 0..7 data, 8 parity, 9 stop.
          frame_n   = {1'b1, frame_r[10:1]};
          bit_idx_n = bit_idx_r + 4'd1;
          if (bit_idx_r == 4'd9) begin
            state_n = ST_ACK;
          end else begin
            state_n = ST_SEND;
          end
        end else begin
          state_n = ST_SEND;
        end
      end

      ST_ACK: begin
        if (tmo_hit_s) begin
          error_n = 1'b1;
          state_n = ST_IDLE;
        end else if (fall_r) begin
          // The device acknowledges by holding data low across this clock fall.
          ack_err_n = dat_sync_r;
          state_n   = ST_WAIT_IDLE;
        end else begin
          state_n = ST_ACK;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_filt_r && dat_sync_r) begin
          done_n  = ~ack_err_r;
          error_n = ack_err_r;
          state_n = ST_IDLE;
        end else if (tmo_hit_s) begin
          error_n = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // The outputs are decoded from the next state, so the registered pins track state_r exactly.
    clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_REQ);
    dat_oe_n = (state_n == ST_REQ) || ((state_n == ST_SEND) && !frame_n[0]);
    busy_n   = (state_n != ST_IDLE);
  end

  // State, datapath and output registers. Reset releases both pins on the next edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      frame_r   <= 11'd0;
      bit_idx_r <= 4'd0;
      inh_cnt_r <= 13'd0;
      tmo_cnt_r <= 20'd0;
      ack_err_r <= 1'b0;
      clk_oe_r  <= 1'b0;
      dat_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      frame_r   <= frame_n;
      bit_idx_r <= bit_idx_n;
      inh_cnt_r <= inh_cnt_n;
      tmo_cnt_r <= tmo_cnt_n;
      ack_err_r <= ack_err_n;
      clk_oe_r  <= clk_oe_n;
      dat_oe_r  <= dat_oe_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      error_r   <= error_n;
    end
  end

  assign Ps2ClkOe = clk_oe_r;
  assign Ps2DatOe = dat_oe_r;
  assign TxBusy   = busy_r;
  assign TxDone   = done_r;
  assign TxError  = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device drives the
// open-drain bus. Expected frame bits and transfer results are queued when a
// byte is submitted. They are popped and compared as the device samples the
// data line and as the result pulse appears. The inhibit and timeout lengths
// are scaled down to keep the run short.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 600;
  localparam int TMO  = 4000;
  localparam int HALF = 100;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] TxData;
  logic       TxStart;
  logic       TxBusy;
  logic       TxDone;
  logic       TxError;
  logic       Ps2ClkIn;
  logic       Ps2DatIn;
  logic       Ps2ClkOe;
  logic       Ps2DatOe;

  // Device-side drive levels: 1 = released, 0 = pulled low
  logic dev_clk;
  logic dev_dat;

  // Wired-AND open-drain bus shared by host and device
  assign Ps2ClkIn = dev_clk & ~Ps2ClkOe;
  assign Ps2DatIn = dev_dat & ~Ps2DatOe;

  int n_vec = 0;
  int n_err = 0;

  bit          exp_bits_q[$];
  logic [1:0]  exp_res_q[$];   // {error, done}
  logic [10:0] last_bits;
  int          last_inh;
  int          last_req;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .TxData(TxData),
    .TxStart(TxStart),
    .TxBusy(TxBusy),
    .TxDone(TxDone),
    .TxError(TxError),
    .Ps2ClkIn(Ps2ClkIn),
    .Ps2DatIn(Ps2DatIn),
    .Ps2ClkOe(Ps2ClkOe),
    .Ps2DatOe(Ps2DatOe)
  );

  always #5 Clock = ~Clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Submit a byte and queue its expected frame (start, data LSB first, odd parity, stop)
  task automatic start_tx(input logic [7:0] b, input logic [1:0] res);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < 11; i++) exp_bits_q.push_back(f[i]);
    exp_res_q.push_back(res);
    TxData  = b;
    TxStart = 1'b1;
    tick(1);
    TxStart = 1'b0;
    n_vec++;
    if (TxBusy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %b want 1", TxBusy);
    end
  endtask

  // Device model: measure the request, clock n_falls bits, then the optional ACK clock.
  // ack_mode: 0 none, 1 ACK (data low), 2 no ACK (data high). glitch_after: fall index
  // whose high phase carries a 3-cycle clock glitch (-1 for none).
  task automatic dev_frame(input int n_falls, input int ack_mode, input int glitch_after);
    int   inh;
    int   req;
    logic v;
    bit   e;
    inh = 0;
    while (Ps2ClkOe === 1'b1 && Ps2DatOe === 1'b0 && inh < INH + 50) begin
      inh++;
      tick(1);
    end
    req = 0;
    while (Ps2ClkOe === 1'b1 && Ps2DatOe === 1'b1 && req < 10) begin
      req++;
      tick(1);
    end
    last_inh = inh;
    last_req = req;
    n_vec++;
    if (!(Ps2ClkOe === 1'b0 && Ps2DatOe === 1'b1)) begin
      n_err++;
      $display("FAIL send_entry: got clkoe=%b datoe=%b want 0/1", Ps2ClkOe, Ps2DatOe);
    end
    tick(40);
    for (int k = 0; k <= n_falls; k++) begin
      if (k > 0) begin
        dev_clk = 1'b0;
        tick(HALF);
      end
      v = Ps2DatIn;
      last_bits[k] = v;
      n_vec++;
      if (exp_bits_q.size() == 0) begin
        n_err++;
        $display("FAIL frame_bit%0d: got %b, nothing expected", k, v);
      end else begin
        e = exp_bits_q.pop_front();
        if (v !== e) begin
          n_err++;
          $display("FAIL frame_bit%0d: got %b want %b", k, v, e);
        end
      end
      if (k > 0) begin
        dev_clk = 1'b1;
        if (k == glitch_after) begin
          tick(40);
          dev_clk = 1'b0;
          tick(3);
          dev_clk = 1'b1;
          tick(HALF - 43);
        end else begin
          tick(HALF);
        end
      end
    end
    if (ack_mode != 0) begin
      tick(20);
      if (ack_mode == 1) dev_dat = 1'b0;
      tick(20);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      if (ack_mode == 1) begin
        tick(30);
        dev_dat = 1'b1;
      end
    end
  endtask

  // Result monitor: wait for the pulse, compare it with the queued result, check it lasts one cycle
  task automatic wait_result(input int limit);
    int         n;
    logic [1:0] e;
    n = 0;
    while (TxDone !== 1'b1 && TxError !== 1'b1 && n < limit) begin
      n++;
      tick(1);
    end
    n_vec++;
    if (n >= limit) begin
      n_err++;
      $display("FAIL result_wait: no TxDone/TxError within %0d cycles", limit);
      if (exp_res_q.size() > 0) void'(exp_res_q.pop_front());
    end else begin
      e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 2'bxx;
      if ({TxError, TxDone} !== e) begin
        n_err++;
        $display("FAIL result: got err/done=%b want %b", {TxError, TxDone}, e);
      end
      n_vec++;
      if (TxBusy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_in_pulse: got %b want 0", TxBusy);
      end
      tick(1);
      n_vec++;
      if ({TxError, TxDone, TxBusy} !== 3'b000) begin
        n_err++;
        $display("FAIL pulse_width: got err/done/busy=%b want 000", {TxError, TxDone, TxBusy});
      end
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    TxStart = 1'b0;
    TxData  = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick(3);
    n_vec++;
    if ({TxBusy, TxDone, TxError, Ps2ClkOe, Ps2DatOe} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000",
               {TxBusy, TxDone, TxError, Ps2ClkOe, Ps2DatOe});
    end
    Reset = 1'b0;
    tick(5);
    n_vec++;
    if ({TxBusy, TxDone, TxError, Ps2ClkOe, Ps2DatOe} !== 5'b00000) begin
      n_err++;
      $display("FAIL idle_outputs: got %b want 00000",
               {TxBusy, TxDone, TxError, Ps2ClkOe, Ps2DatOe});
    end
  endtask

  task automatic test_send_ed();
    start_tx(8'hED, 2'b01);
    dev_frame(10, 1, -1);
    n_vec++;
    if (last_inh != INH) begin
      n_err++;
      $display("FAIL inhibit_len: got %0d want %0d", last_inh, INH);
    end
    n_vec++;
    if (last_req != 1) begin
      n_err++;
      $display("FAIL req_len: got %0d want 1", last_req);
    end
    n_vec++;
    if (last_bits !== 11'h7DA) begin
      n_err++;
      $display("FAIL ed_bits: got %b want %b", last_bits, 11'h7DA);
    end
    wait_result(200);
  endtask

  task automatic test_parity();
    logic [7:0] bytes[3];
    logic       par[3];
    bytes = '{8'h01, 8'h00, 8'hFF};
    par   = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      tick(20);
      start_tx(bytes[i], 2'b01);
      dev_frame(10, 1, -1);
      n_vec++;
      if (last_bits[9] !== par[i]) begin
        n_err++;
        $display("FAIL parity_%h: got %b want %b", bytes[i], last_bits[9], par[i]);
      end
      wait_result(200);
    end
  endtask

  task automatic test_nack();
    tick(20);
    start_tx(8'h12, 2'b10);
    dev_frame(10, 2, -1);
    wait_result(300);
  endtask

  task automatic test_timeout();
    int         n;
    logic [1:0] e;
    tick(20);
    start_tx(8'h3C, 2'b10);
    exp_bits_q.delete();
    n = 0;
    while (Ps2ClkOe === 1'b1 && Ps2DatOe === 1'b0 && n < INH + 50) begin
      n++;
      tick(1);
    end
    n = 0;
    while (Ps2ClkOe === 1'b1 && n < 10) begin
      n++;
      tick(1);
    end
    // First SEND cycle: the REQ exit edge was the preceding posedge.
    n = 0;
    while (TxError !== 1'b1 && n < TMO + 100) begin
      n++;
      tick(1);
    end
    n_vec++;
    if (n != TMO) begin
      n_err++;
      $display("FAIL timeout_len: got %0d want %0d", n, TMO);
    end
    n_vec++;
    if ({Ps2ClkOe, Ps2DatOe, TxDone, TxBusy} !== 4'b0000) begin
      n_err++;
      $display("FAIL timeout_state: got clkoe/datoe/done/busy=%b want 0000",
               {Ps2ClkOe, Ps2DatOe, TxDone, TxBusy});
    end
    e = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 2'bxx;
    n_vec++;
    if ({TxError, TxDone} !== e) begin
      n_err++;
      $display("FAIL timeout_result: got err/done=%b want %b", {TxError, TxDone}, e);
    end
    tick(1);
    n_vec++;
    if (TxError !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse_width: got %b want 0", TxError);
    end
  endtask

  task automatic test_reset_mid_frame();
    tick(20);
    start_tx(8'h0F, 2'b01);
    dev_frame(5, 0, -1);
    n_vec++;
    if ({Ps2ClkOe, Ps2DatOe, TxBusy} !== 3'b011) begin
      n_err++;
      $display("FAIL mid_frame_idx4: got clkoe/datoe/busy=%b want 011",
               {Ps2ClkOe, Ps2DatOe, TxBusy});
    end
    Reset = 1'b1;
    tick(1);
    n_vec++;
    if ({Ps2ClkOe, Ps2DatOe, TxBusy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release: got clkoe/datoe/busy=%b want 000",
               {Ps2ClkOe, Ps2DatOe, TxBusy});
    end
    Reset = 1'b0;
    exp_bits_q.delete();
    exp_res_q.delete();
    tick(20);
    start_tx(8'hF4, 2'b01);
    dev_frame(10, 1, -1);
    wait_result(200);
  endtask

  task automatic test_busy_ignore_glitch();
    tick(20);
    start_tx(8'h55, 2'b01);
    fork
      dev_frame(10, 1, 3);
      begin
        tick(INH + 250);
        TxData  = 8'hAA;
        TxStart = 1'b1;
        tick(1);
        TxStart = 1'b0;
        n_vec++;
        if (TxBusy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_during_ignored_start: got %b want 1", TxBusy);
        end
      end
    join
    wait_result(200);
    n_vec++;
    if (exp_bits_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_bits: got %0d queued want 0", exp_bits_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid_frame();
    test_busy_ignore_glitch();
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
